// File: rtl/parity_rx_pkg.sv
// Shared definitions for the XOR-parity serial link: FSM encodings, line idle level, frame length.
package parity_rx_pkg;

  // Receiver FSM states, 3-bit encoding shared with the matching transmitter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
  } state_t;

  // Level of the serial line between frames; a start bit is the opposite level.
  localparam logic LINE_IDLE = 1'b1;

  // Number of bit_en samples occupied by one frame: start + data + parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/parity_rx_if.sv
// Line input and frame output handshake of the parity receiver.
interface parity_rx_if #(
  parameter int unsigned DATA_W = 8
);

  logic              bit_en;
  logic              rx_bit;
  logic [DATA_W-1:0] out_data;
  logic              out_par_err;
  logic              out_frame_err;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  // Receiver side: samples the line, presents frames.
  modport master (
    input  bit_en, rx_bit, out_ready,
    output out_data, out_par_err, out_frame_err, out_valid, overrun
  );

  // Environment side: drives the line, consumes frames.
  modport slave (
    output bit_en, rx_bit, out_ready,
    input  out_data, out_par_err, out_frame_err, out_valid, overrun
  );

endinterface

// File: rtl/parity_acc.sv
// 1-bit running XOR accumulator with synchronous clear and enable; shared with the transmitter.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  // Clear wins over accumulate so a new frame always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start/data/parity/stop deserializer with XOR parity and stop-bit checks,
// presenting each frame on a single-entry valid/ready output register.
module parity_rx
  import parity_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  parity_rx_if.master     bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                acc_q;
  logic                acc_clr_c;
  logic                acc_en_c;
  logic                comp_c;
  logic                comp_par_err_c;
  logic                comp_frame_err_c;

  logic [DATA_W-1:0]   data_d;
  logic                par_err_d;
  logic                frame_err_d;
  logic                valid_d;
  logic                overrun_d;

  parity_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr_c),
    .en    (acc_en_c),
    .d     (bus.rx_bit),
    .q     (acc_q)
  );

  // FSM state, bit counter and data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Next-state and datapath control; nothing moves on edges without bit_en.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    shift_d          = shift_q;
    acc_clr_c        = 1'b0;
    acc_en_c         = 1'b0;
    comp_c           = 1'b0;
    comp_par_err_c   = acc_q ^ PARITY_ODD;
    comp_frame_err_c = (bus.rx_bit != LINE_IDLE);
    if (bus.bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_bit != LINE_IDLE) begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            shift_d   = '0;
            acc_clr_c = 1'b1;
          end
        end
        ST_DATA: begin
          // LSB arrives first; shifting in at the top leaves it at bit 0 after DATA_W bits.
          shift_d  = (shift_q >> 1) | (DATA_W'(bus.rx_bit) << (DATA_W - 1));
          acc_en_c = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          acc_en_c = 1'b1;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          comp_c  = 1'b1;
          state_d = (bus.rx_bit == LINE_IDLE) ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          // A stuck-low line must return to idle before a new start can be seen.
          if (bus.rx_bit == LINE_IDLE) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output register next values: load on completion when empty or draining, else drop and flag.
  always_comb begin
    data_d      = bus.out_data;
    par_err_d   = bus.out_par_err;
    frame_err_d = bus.out_frame_err;
    valid_d     = bus.out_valid;
    overrun_d   = 1'b0;
    if (comp_c) begin
      if (!bus.out_valid || bus.out_ready) begin
        data_d      = shift_q;
        par_err_d   = comp_par_err_c;
        frame_err_d = comp_frame_err_c;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.out_valid && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Registered frame outputs and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data      <= '0;
      bus.out_par_err   <= 1'b0;
      bus.out_frame_err <= 1'b0;
      bus.out_valid     <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.out_data      <= data_d;
      bus.out_par_err   <= par_err_d;
      bus.out_frame_err <= frame_err_d;
      bus.out_valid     <= valid_d;
      bus.overrun       <= overrun_d;
    end
  end

endmodule
